uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame, range 5..8.
REQ-002 Parameter SB_TICK, default 16: stop-bit length in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Port clk  input  1: single clock; every register updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port s_tick  input  1: 16x-oversampling enable, one-cycle pulse from the baud-rate generator, 16 pulses per bit time.
REQ-006 Port tx_start  input  1: request to send din; level-sampled, acted on only in IDLE.
REQ-007 Port din  input  8: byte to transmit; bits [DBIT-1:0] are used.
REQ-008 Port tx_done_tick  output  1: one-cycle pulse marking the end of a frame.
REQ-009 Port tx  output  1: serial line, idle high, driven from a register.

Function
REQ-010 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-011 Internal state: 4-bit tick counter s, 3-bit bit counter n, DBIT-bit shift register b, tx register.
REQ-012 IDLE, tx_start=1: load b<=din[DBIT-1:0], s<=0, tx<=0, go to START on the same edge.
- An s_tick in that same cycle SHALL NOT be counted.
REQ-013 IDLE, tx_start=0: no state change; tx held at 1.
REQ-014 START, s_tick=1, s=15: s<=0, n<=0, tx<=b[0], go to DATA.
- Otherwise, on s_tick, s<=s+1.
REQ-015 DATA, s_tick=1, s=15: s<=0, b<=b>>1, go to the next bit.
- If n=DBIT-1: tx<=1 and go to STOP.
- Else: n<=n+1 and tx<=b[1], i.e. LSB first.
- Otherwise, on s_tick, s<=s+1.
REQ-016 STOP, s_tick=1, s=SB_TICK-1: assert tx_done_tick combinationally for that cycle and go to IDLE at the next edge.
- Otherwise, on s_tick, s<=s+1.
- SB_TICK>16 requires s to be widened to clog2(SB_TICK) bits.
REQ-017 When s_tick=0, s, n, b, tx and the state SHALL hold in every state.
REQ-018 tx_start SHALL be ignored in START, DATA and STOP; changes on din after acceptance SHALL NOT affect the frame in flight.
REQ-019 Frame length SHALL be exactly 16 + 16*DBIT + SB_TICK s_tick pulses after the accepting edge.
REQ-020 tx_start held high through the tx_done_tick cycle SHALL start the next frame on the first edge in IDLE, giving one clk of idle-high between frames.
REQ-021 tx_done_tick SHALL be high for exactly one clk per frame and never outside STOP.

Reset
REQ-022 On a clk edge with reset=1: state<=IDLE, s<=0, n<=0, b<=0, tx<=1; tx_done_tick is 0 from that edge.
REQ-023 Reset asserted mid-frame SHALL abort the frame: tx goes high at that edge, no tx_done_tick, and tx_start is ignored while reset=1.
REQ-024 After reset deasserts, the first tx_start SHALL start a clean frame from START.

Verification
REQ-025 s_tick tied to 1, DBIT=8, SB_TICK=16, din=0xA5, tx_start pulsed one cycle:
- tx = 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles.
- tx_done_tick high only in cycle 160 after the accepting edge.
REQ-026 s_tick one pulse every 5 clk, din=0x3C: each bit lasts 80 clk; the sampled bits reconstruct 0x3C; tx_done_tick once.
REQ-027 tx_start pulsed again with din=0xFF during DATA of a 0x00 frame: the 0x00 frame completes unchanged; no second frame starts.
REQ-028 tx_start held high, din=0x55 then 0xAA: two frames; exactly 1 idle-high clk between them; two tx_done_tick pulses.
REQ-029 reset asserted for 1 cycle at bit 3 of a frame: tx=1 after that edge; no tx_done_tick; a following tx_start with 0x81 produces a correct frame.
REQ-030 SB_TICK=32 with s_tick tied to 1: stop bit high for 32 cycles; tx_done_tick in cycle 176.

Source files
------------

// File: rtl/uart_tx_if.sv
// UART transmitter bundle: tick/request/data in, serial line and frame-done out.
interface uart_tx_if;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx_done_tick;
    logic       tx;

    // Master drives the transmitter (baud generator + byte source).
    modport master (
        output s_tick,
        output tx_start,
        output din,
        input  tx_done_tick,
        input  tx
    );

    // Slave is the transmitter itself.
    modport slave (
        input  s_tick,
        input  tx_start,
        input  din,
        output tx_done_tick,
        output tx
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, SB_TICK/16 stop bits,
// timed by a 16x oversampling tick.
module uart_tx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   tx_if
);

    // Tick counter must hold SB_TICK-1 for long stop bits.
    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam logic [SW-1:0] SBitLast  = SW'(15);
    localparam logic [SW-1:0] SStopLast = SW'(SB_TICK - 1);
    localparam logic [2:0]    NLast     = 3'(DBIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [2:0]        n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic              tx_q, tx_d;
    logic              done;

    // State register with synchronous reset; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state and frame-done decode; everything holds when s_tick is low.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        tx_d    = tx_q;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (tx_if.tx_start) begin
                    // A tick in the accepting cycle is deliberately not counted.
                    state_d = StStart;
                    s_d     = '0;
                    b_d     = tx_if.din[DBIT-1:0];
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (tx_if.s_tick) begin
                    if (s_q == SBitLast) begin
                        state_d = StData;
                        s_d     = '0;
                        n_d     = '0;
                        tx_d    = b_q[0];
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            StData: begin
                if (tx_if.s_tick) begin
                    if (s_q == SBitLast) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == NLast) begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end else begin
                            n_d  = n_q + 3'd1;
                            tx_d = b_q[1];
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            StStop: begin
                if (tx_if.s_tick) begin
                    if (s_q == SStopLast) begin
                        state_d = StIdle;
                        s_d     = '0;
                        done    = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign tx_if.tx           = tx_q;
    assign tx_if.tx_done_tick = done;

endmodule
